// File: rtl/eth_phy_10g_pkg.sv
`default_nettype none
// ============================================================================
// Package     : eth_phy_10g_pkg
// Description : Shared constants and helpers for the 10GBASE-R receive link
//               monitor: sync header encodings, counter widths and a
//               header-validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_phy_10g_pkg;

    // Sync header width; the monitor only supports 2-bit 64b/66b headers
    localparam int HDR_W = 2;

    localparam logic [HDR_W-1:0] SYNC_DATA = 2'b10;
    localparam logic [HDR_W-1:0] SYNC_CTRL = 2'b01;

    // Counter widths
    localparam int SH_CNT_W   = 6;   // headers per alignment group (64)
    localparam int INV_CNT_W  = 4;   // invalid headers per group (16th unlocks)
    localparam int BER_CNT_W  = 4;   // invalid headers per window, saturating
    localparam int ERR_CNT_W  = 4;   // consecutive bad windows
    localparam int STAT_CNT_W = 4;   // good windows, saturating
    localparam int BLK_ERR_W  = 10;  // decoder errors per window, saturating

    // 01 and 10 are the only legal sync headers; 00 and 11 are invalid
    function automatic logic hdr_valid(input logic [HDR_W-1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage : eth_phy_10g_pkg
`default_nettype wire

// File: rtl/eth_phy_10g_rx_link_mon_if.sv
`default_nettype none
// ============================================================================
// Interface   : eth_phy_10g_rx_link_mon_if
// Description : Signal bundle between the SERDES gearbox / PCS decoder side
//               and the receive link monitor.
//   master : drives sync header, decoder error flags and PRBS mode;
//            receives bitslip, reset request and link status.
//   slave  : the link monitor itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_phy_10g_rx_link_mon_if;
    import eth_phy_10g_pkg::*;

    logic [HDR_W-1:0] serdes_rx_hdr;
    logic             rx_bad_block;
    logic             rx_sequence_error;
    logic             rx_prbs31_enable;
    logic             serdes_rx_bitslip;
    logic             serdes_rx_reset_req;
    logic             rx_block_lock;
    logic             rx_high_ber;
    logic             rx_status;

    modport master (
        output serdes_rx_hdr,
        output rx_bad_block,
        output rx_sequence_error,
        output rx_prbs31_enable,
        input  serdes_rx_bitslip,
        input  serdes_rx_reset_req,
        input  rx_block_lock,
        input  rx_high_ber,
        input  rx_status
    );

    modport slave (
        input  serdes_rx_hdr,
        input  rx_bad_block,
        input  rx_sequence_error,
        input  rx_prbs31_enable,
        output serdes_rx_bitslip,
        output serdes_rx_reset_req,
        output rx_block_lock,
        output rx_high_ber,
        output rx_status
    );

endinterface : eth_phy_10g_rx_link_mon_if
`default_nettype wire

// File: rtl/eth_phy_10g_rx_win_timer.sv
`default_nettype none
// ============================================================================
// Module      : eth_phy_10g_rx_win_timer
// Description : Free-running window timer shared by the BER monitor and the
//               watchdog. Counts down from COUNT_125US; the cycle it reads
//               zero it asserts o_tick and reloads, giving a period of
//               COUNT_125US+1 cycles.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset (loads COUNT_125US)
//               o_tick - one-cycle window boundary strobe
// Revision    : 1.0 - initial release
// ============================================================================
module eth_phy_10g_rx_win_timer #(
    parameter int COUNT_125US = 19531
) (
    input  wire  clk,
    input  wire  rst_n,
    output logic o_tick
);

    localparam int              c_cnt_w  = (COUNT_125US < 1) ? 1 : $clog2(COUNT_125US + 1);
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(COUNT_125US);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= c_reload;
        end else if (r_cnt == '0) begin
            r_cnt <= c_reload;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Decoded from the count register, so the strobe is glitch-free and
    // lines up with the reload edge
    assign o_tick = (r_cnt == '0);

endmodule : eth_phy_10g_rx_win_timer
`default_nettype wire

// File: rtl/eth_phy_10g_rx_link_mon.sv
`default_nettype none
// ============================================================================
// Module      : eth_phy_10g_rx_link_mon
// Description : 10GBASE-R receive link monitor between the SERDES gearbox
//               and the PCS decoder.
//   - Block sync : locks 66b alignment on the sync header, drives bitslip.
//   - BER monitor: flags a high bit-error rate per window.
//   - Watchdog   : requests a SERDES reset when the link never becomes
//                  healthy; reports link status.
// Ports       : clk   - clock, all logic rising-edge
//               rst_n - asynchronous active-low reset
//               mon   - slave side of eth_phy_10g_rx_link_mon_if
//                       (in : serdes_rx_hdr, rx_bad_block,
//                             rx_sequence_error, rx_prbs31_enable;
//                        out: serdes_rx_bitslip, serdes_rx_reset_req,
//                             rx_block_lock, rx_high_ber, rx_status)
// Revision    : 1.0 - initial release
// ============================================================================
module eth_phy_10g_rx_link_mon
    import eth_phy_10g_pkg::*;
#(
    parameter int HDR_WIDTH           = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int COUNT_125US         = 19531
) (
    input  wire                        clk,
    input  wire                        rst_n,
    eth_phy_10g_rx_link_mon_if.slave   mon
);

    generate
        if (HDR_WIDTH != HDR_W) begin : g_hdr_width_check
            $error("eth_phy_10g_rx_link_mon: HDR_WIDTH must be 2");
        end
    endgenerate

    // Zero-length slip phases would never release bitslip; clamp to 1
    localparam int c_slip_hi = (BITSLIP_HIGH_CYCLES < 1) ? 1 : BITSLIP_HIGH_CYCLES;
    localparam int c_slip_lo = (BITSLIP_LOW_CYCLES  < 1) ? 1 : BITSLIP_LOW_CYCLES;
    localparam int c_slip_mx = (c_slip_hi > c_slip_lo) ? c_slip_hi : c_slip_lo;
    localparam int c_slip_w  = (c_slip_mx < 2) ? 1 : $clog2(c_slip_mx);

    localparam logic [c_slip_w-1:0]   c_slip_hi_load = c_slip_w'(c_slip_hi - 1);
    localparam logic [c_slip_w-1:0]   c_slip_lo_load = c_slip_w'(c_slip_lo - 1);
    localparam logic [SH_CNT_W-1:0]   c_sh_max       = '1;
    localparam logic [INV_CNT_W-1:0]  c_inv_max      = '1;
    localparam logic [BER_CNT_W-1:0]  c_ber_max      = '1;
    localparam logic [ERR_CNT_W-1:0]  c_err_max      = '1;
    localparam logic [STAT_CNT_W-1:0] c_stat_max     = '1;
    localparam logic [BLK_ERR_W-1:0]  c_blk_max      = '1;

    logic w_tick;
    logic w_hdr_valid;
    logic w_ctrl_seen;
    logic w_blk_evt;

    logic [SH_CNT_W-1:0]   r_sh_cnt;
    logic [INV_CNT_W-1:0]  r_inv_cnt;
    logic [c_slip_w-1:0]   r_slip_cnt;
    logic                  r_bitslip;
    logic                  r_lock;

    logic [BER_CNT_W-1:0]  r_ber_cnt;
    logic                  r_high_ber;

    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic [STAT_CNT_W-1:0] r_stat_cnt;
    logic [BLK_ERR_W-1:0]  r_blk_err;
    logic                  r_saw_ctrl;
    logic                  r_reset_req;

    eth_phy_10g_rx_win_timer #(
        .COUNT_125US (COUNT_125US)
    ) u_win_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_hdr_valid = hdr_valid(mon.serdes_rx_hdr);
    assign w_ctrl_seen = r_lock && (mon.serdes_rx_hdr == SYNC_CTRL);
    assign w_blk_evt   = mon.rx_bad_block | mon.rx_sequence_error;

    // ------------------------------------------------------------------
    // Block sync. A slip is a high phase (bitslip asserted) followed by a
    // low phase; headers are ignored throughout because the gearbox output
    // is not yet realigned.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_cnt   <= '0;
            r_inv_cnt  <= '0;
            r_slip_cnt <= '0;
            r_bitslip  <= 1'b0;
            r_lock     <= 1'b0;
        end else if (r_slip_cnt != '0) begin
            r_slip_cnt <= r_slip_cnt - 1'b1;
        end else if (r_bitslip) begin
            r_bitslip  <= 1'b0;
            r_slip_cnt <= c_slip_lo_load;
        end else if (w_hdr_valid) begin
            if (r_sh_cnt == c_sh_max) begin
                // 64-header group complete; lock only on a clean group
                r_sh_cnt  <= '0;
                r_inv_cnt <= '0;
                if (r_inv_cnt == '0) begin
                    r_lock <= 1'b1;
                end
            end else begin
                r_sh_cnt <= r_sh_cnt + 1'b1;
            end
        end else begin
            if (!r_lock || (r_inv_cnt == c_inv_max)) begin
                // Hunting, or 16th bad header in this group: slip one bit
                r_sh_cnt   <= '0;
                r_inv_cnt  <= '0;
                r_lock     <= 1'b0;
                r_bitslip  <= 1'b1;
                r_slip_cnt <= c_slip_hi_load;
            end else if (r_sh_cnt == c_sh_max) begin
                r_sh_cnt  <= '0;
                r_inv_cnt <= '0;
            end else begin
                r_sh_cnt  <= r_sh_cnt + 1'b1;
                r_inv_cnt <= r_inv_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // BER monitor. A window that saturates the counter keeps the flag set
    // across the following window so the flag is never shorter than one
    // full window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ber_cnt  <= '0;
            r_high_ber <= 1'b0;
        end else if (w_tick) begin
            r_ber_cnt <= '0;
            if (r_ber_cnt != c_ber_max) begin
                r_high_ber <= 1'b0;
            end
        end else if (!w_hdr_valid && (r_ber_cnt != c_ber_max)) begin
            r_ber_cnt <= r_ber_cnt + 1'b1;
            if (r_ber_cnt == (c_ber_max - 1'b1)) begin
                r_high_ber <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog. A window is good when a control block was seen while locked
    // and the decoder error count did not saturate. Sixteen bad windows in
    // a row request a SERDES reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt   <= '0;
            r_stat_cnt  <= '0;
            r_blk_err   <= '0;
            r_saw_ctrl  <= 1'b0;
            r_reset_req <= 1'b0;
        end else begin
            r_reset_req <= 1'b0;
            if (w_tick) begin
                r_saw_ctrl <= 1'b0;
                r_blk_err  <= '0;
                if (r_err_cnt == c_err_max) begin
                    r_err_cnt   <= '0;
                    r_stat_cnt  <= '0;
                    r_reset_req <= ~mon.rx_prbs31_enable;
                end else if (!r_saw_ctrl || (r_blk_err == c_blk_max)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end else begin
                    r_err_cnt <= '0;
                    if (r_stat_cnt != c_stat_max) begin
                        r_stat_cnt <= r_stat_cnt + 1'b1;
                    end
                end
            end else begin
                if (w_ctrl_seen) begin
                    r_saw_ctrl <= 1'b1;
                end
                if (w_blk_evt && (r_blk_err != c_blk_max)) begin
                    r_blk_err <= r_blk_err + 1'b1;
                end
            end
        end
    end

    // Alignment keeps running in PRBS mode; only the pin is held low
    assign mon.serdes_rx_bitslip   = r_bitslip & ~mon.rx_prbs31_enable;
    assign mon.serdes_rx_reset_req = r_reset_req;
    assign mon.rx_block_lock       = r_lock;
    assign mon.rx_high_ber         = r_high_ber;
    assign mon.rx_status           = (r_stat_cnt == c_stat_max);

endmodule : eth_phy_10g_rx_link_mon
`default_nettype wire

// File: tb/tb_eth_phy_10g_rx_link_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_phy_10g_rx_link_mon
// Description : Testbench for eth_phy_10g_rx_link_mon. Two instances share
//               one stimulus stream: a short-window one (COUNT_125US=99) and
//               a long-window one (COUNT_125US=1099) so a window can hold
//               1023 decoder errors. A behavioural model tracks each
//               instance and every output is compared each cycle, plus
//               directed checks at the interesting points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_phy_10g_rx_link_mon;

    localparam int CNT_S = 99;
    localparam int CNT_B = 1099;
    localparam int BS_HI = 1;
    localparam int BS_LO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] r_hdr;
    logic       r_bad;
    logic       r_seq;
    logic       r_prbs;

    always #5 clk = ~clk;

    eth_phy_10g_rx_link_mon_if if_s ();
    eth_phy_10g_rx_link_mon_if if_b ();

    assign if_s.serdes_rx_hdr     = r_hdr;
    assign if_s.rx_bad_block      = r_bad;
    assign if_s.rx_sequence_error = r_seq;
    assign if_s.rx_prbs31_enable  = r_prbs;
    assign if_b.serdes_rx_hdr     = r_hdr;
    assign if_b.rx_bad_block      = r_bad;
    assign if_b.rx_sequence_error = r_seq;
    assign if_b.rx_prbs31_enable  = r_prbs;

    eth_phy_10g_rx_link_mon #(
        .HDR_WIDTH           (2),
        .BITSLIP_HIGH_CYCLES (BS_HI),
        .BITSLIP_LOW_CYCLES  (BS_LO),
        .COUNT_125US         (CNT_S)
    ) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (if_s)
    );

    eth_phy_10g_rx_link_mon #(
        .HDR_WIDTH           (2),
        .BITSLIP_HIGH_CYCLES (BS_HI),
        .BITSLIP_LOW_CYCLES  (BS_LO),
        .COUNT_125US         (CNT_B)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (if_b)
    );

    // ------------------------------------------------------------------
    // Reference model: 64-header groups, an "ignore" countdown covering the
    // whole slip, window boundaries from the edge count since reset.
    // ------------------------------------------------------------------
    typedef struct {
        int grp;   // headers seen in current group
        int bad;   // invalid headers in current group
        int lock;
        int ign;   // headers still to ignore because of a slip
        int ber;   // invalid headers this window (max 15)
        int high;
        int saw;   // control header seen while locked this window
        int blk;   // decoder errors this window (max 1023)
        int err;   // consecutive bad windows
        int stat;  // good windows (max 15)
        int rreq;
        int cyc;   // rising edges since reset release
    } mdl_t;

    mdl_t m [2];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic int per(input int k);
        return (k == 0) ? (CNT_S + 1) : (CNT_B + 1);
    endfunction

    function automatic void mstep(input int k);
        mdl_t s;
        mdl_t n;
        bit   inv;
        bit   tick;
        s    = m[k];
        n    = s;
        inv  = !((r_hdr == 2'b01) || (r_hdr == 2'b10));
        n.cyc  = s.cyc + 1;
        tick   = ((n.cyc % per(k)) == 0);
        n.rreq = 0;
        // alignment
        if (s.ign > 0) begin
            n.ign = s.ign - 1;
        end else begin
            n.grp = s.grp + 1;
            n.bad = s.bad + (inv ? 1 : 0);
            if (inv && (s.lock == 0 || n.bad == 16)) begin
                n.lock = 0; n.grp = 0; n.bad = 0;
                n.ign  = BS_HI + BS_LO - 1;
            end else if (n.grp == 64) begin
                if (n.bad == 0) n.lock = 1;
                n.grp = 0; n.bad = 0;
            end
        end
        // BER
        if (tick) begin
            n.ber = 0;
            if (s.ber < 15) n.high = 0;
        end else if (inv && s.ber < 15) begin
            n.ber = s.ber + 1;
            if (n.ber == 15) n.high = 1;
        end
        // watchdog
        if (tick) begin
            n.saw = 0; n.blk = 0;
            if (s.err == 15) begin
                n.err = 0; n.stat = 0; n.rreq = r_prbs ? 0 : 1;
            end else if (s.saw == 0 || s.blk == 1023) begin
                n.err = s.err + 1;
            end else begin
                n.err = 0;
                if (s.stat < 15) n.stat = s.stat + 1;
            end
        end else begin
            if (s.lock != 0 && r_hdr == 2'b01) n.saw = 1;
            if ((r_bad || r_seq) && s.blk < 1023) n.blk = s.blk + 1;
        end
        m[k] = n;
    endfunction

    // {bitslip, reset_req, block_lock, high_ber, status}
    function automatic logic [4:0] mexp(input int k);
        return {(m[k].ign >= BS_LO) && !r_prbs, m[k].rreq == 1, m[k].lock == 1,
                m[k].high == 1, m[k].stat == 15};
    endfunction

    function automatic logic [4:0] obs(input int k);
        if (k == 0)
            return {if_s.serdes_rx_bitslip, if_s.serdes_rx_reset_req, if_s.rx_block_lock,
                    if_s.rx_high_ber, if_s.rx_status};
        return {if_b.serdes_rx_bitslip, if_b.serdes_rx_reset_req, if_b.rx_block_lock,
                if_b.rx_high_ber, if_b.rx_status};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_chk++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs_v, exp_v, $time);
        end
    endtask

    // One clock: model steps on the rising edge, outputs compared on the
    // falling edge, next inputs then driven by the caller
    task automatic cyc1();
        @(posedge clk);
        mstep(0);
        mstep(1);
        @(negedge clk);
        check("out_s", {27'd0, obs(0)}, {27'd0, mexp(0)});
        check("out_b", {27'd0, obs(1)}, {27'd0, mexp(1)});
    endtask

    task automatic set_in(input int p_inv, input int p_ctrl, input int p_err);
        if ($urandom_range(99) < p_inv)
            r_hdr = ($urandom_range(1) == 1) ? 2'b11 : 2'b00;
        else
            r_hdr = ($urandom_range(99) < p_ctrl) ? 2'b01 : 2'b10;
        r_bad = ($urandom_range(99) < p_err);
        r_seq = ($urandom_range(99) < p_err);
    endtask

    task automatic run(input int n, input int p_inv, input int p_ctrl, input int p_err);
        for (int i = 0; i < n; i++) begin
            set_in(p_inv, p_ctrl, p_err);
            cyc1();
        end
    endtask

    // Runs until the model of instance k has just consumed a window tick
    task automatic run_to_tick(input int k, input int p_inv, input int p_ctrl, input int p_err);
        do begin
            set_in(p_inv, p_ctrl, p_err);
            cyc1();
        end while ((m[k].cyc % per(k)) != 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        m[0] = '{default: 0};
        m[1] = '{default: 0};
        check("rst_out_s", {27'd0, obs(0)}, 32'd0);
        check("rst_out_b", {27'd0, obs(1)}, 32'd0);
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        r_hdr  = 2'b00;
        r_bad  = 1'b0;
        r_seq  = 1'b0;
        r_prbs = 1'b0;
        rst_n  = 1'b1;
        #2;
        do_reset(2);

        // Lock after 64 consecutive data headers
        r_hdr = 2'b10;
        for (int i = 0; i < 63; i++) cyc1();
        check("lock_pre64", if_s.rx_block_lock, 0);
        cyc1();
        check("lock_at64", if_s.rx_block_lock, 1);
        check("lock_no_slip", if_s.serdes_rx_bitslip, 0);

        // 16 invalid headers in one group drop lock and slip once
        r_hdr = 2'b00;
        for (int i = 0; i < 15; i++) cyc1();
        check("lock_15bad", if_s.rx_block_lock, 1);
        cyc1();
        check("unlock_16bad", if_s.rx_block_lock, 0);
        check("slip_16bad", if_s.serdes_rx_bitslip, 1);
        cyc1();
        check("slip_one_cycle", if_s.serdes_rx_bitslip, 0);
        for (int i = 0; i < 7; i++) cyc1();
        check("slip_ignored", if_s.serdes_rx_bitslip, 0);

        // Unlocked: a single invalid header slips immediately
        r_hdr = 2'b11;
        cyc1();
        check("slip_single_inv", if_s.serdes_rx_bitslip, 1);

        // Reset in the middle of a slip drops bitslip at once
        do_reset(2);

        // Random mixes
        run(2000, 4, 60, 3);
        run(1000, 30, 50, 10);

        // BER: 15th invalid header in a window sets the flag
        do_reset(2);
        run_to_tick(0, 0, 50, 0);
        r_hdr = 2'b00;
        for (int i = 0; i < 14; i++) cyc1();
        check("ber_14", if_s.rx_high_ber, 0);
        cyc1();
        check("ber_15", if_s.rx_high_ber, 1);
        cyc1();
        run_to_tick(0, 0, 50, 0);
        check("ber_hold", if_s.rx_high_ber, 1);
        run_to_tick(0, 0, 50, 0);
        check("ber_clear", if_s.rx_high_ber, 0);

        // Watchdog: never locked, reset request at the 16th tick
        do_reset(2);
        run(16 * per(0) - 1, 100, 0, 0);
        check("wd_pre16", if_s.serdes_rx_reset_req, 0);
        run(1, 100, 0, 0);
        check("wd_pulse", if_s.serdes_rx_reset_req, 1);
        run(1, 100, 0, 0);
        check("wd_one_cycle", if_s.serdes_rx_reset_req, 0);

        // Same stimulus in PRBS mode: no reset request, no bitslip
        r_prbs = 1'b1;
        do_reset(2);
        run(16 * per(0), 100, 0, 0);
        check("wd_prbs", if_s.serdes_rx_reset_req, 0);
        check("slip_prbs", if_s.serdes_rx_bitslip, 0);
        run(50, 50, 50, 0);
        r_prbs = 1'b0;

        // Healthy link: locked, control headers, no decoder errors
        do_reset(2);
        run(15 * per(1) - 1, 0, 100, 0);
        check("stat_pre15", if_b.rx_status, 0);
        run(1, 0, 100, 0);
        check("stat_15", if_b.rx_status, 1);
        // A window full of bad blocks counts as a bad window
        run(per(1), 0, 100, 100);
        check("stat_keep", if_b.rx_status, 1);
        run(per(1), 0, 100, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_eth_phy_10g_rx_link_mon
`default_nettype wire
